mips32_hazard_ctrl: RTL and testbench
=====================================

MIPS32_HAZARD_CTRL -- requirements
Module: mips32_hazard_ctrl

Interface
REQ-001 Parameter WB_LAT, default 2: stall cycles incurred by a dependent instruction issued immediately after its producer (legal range 1..3).
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_rs, id_rt  in  5 each  source register numbers.
REQ-007 id_use_rs, id_use_rt  in  1 each  the instruction reads rs / rt.
REQ-008 id_wr_en, id_rd  in  1, 5  the instruction writes register id_rd.
REQ-009 id_is_load, id_is_branch, id_is_hlt  in  1 each  instruction class flags.
REQ-010 ex_br_resolved, ex_br_taken  in  1 each  one-cycle pulse when the branch resolves; taken qualifier.
REQ-011 stall  out  1  freeze PC and IF/ID.
REQ-012 bubble  out  1  inject NOP into ID/EX.
REQ-013 flush  out  1  kill the IF/ID contents.
REQ-014 halted  out  1  the pipeline is halted.
REQ-015 stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-016 Issue is defined as id_valid & ~stall.
REQ-017 The scoreboard is 31 down-counters, 2 bits each, for R1..R31; R0 never creates a hazard.
REQ-018 On issue with id_wr_en=1 and id_rd!=0, cnt[id_rd] loads WB_LAT; every other nonzero counter decrements by 1 each cycle.
REQ-019 When a load and a decrement hit the same register in one cycle, the load wins.
REQ-020 Hazard is combinational: id_valid & ((id_use_rs & cnt[id_rs]!=0) | (id_use_rt & cnt[id_rt]!=0)).
REQ-021 FSM states are RUN, BR_WAIT, DRAIN, HALT.
REQ-022 In RUN, issue of a branch moves the FSM to BR_WAIT; issue of HLT moves it to DRAIN.
REQ-023 In BR_WAIT, the FSM returns to RUN on ex_br_resolved; flush=1 in that same cycle if ex_br_taken=1, otherwise flush=0.
REQ-024 In DRAIN, the FSM moves to HALT in the cycle all counters are 0.
REQ-025 HALT is held until rst.
REQ-026 stall = hazard | (state!=RUN); bubble = stall & id_valid; halted = (state==HALT).
REQ-027 ex_br_resolved in any state other than BR_WAIT is ignored: no flush and no state change.
REQ-028 stall_cnt increments in each cycle with stall=1 and state!=HALT, and saturates at all-ones with no wrap.
REQ-029 Decision latency is zero: outputs are valid in the same cycle as the ID inputs.

Reset
REQ-030 rst=1 clears all counters, sets state to RUN and stall_cnt to 0.
REQ-031 Reset values: stall=hazard-free 0, bubble=0, flush=0, halted=0.
REQ-032 Reset asserted mid-branch or mid-drain abandons that operation with no residual flush.

Configuration
REQ-033 Macro HAZ_FWD_EN selects forwarding-aware scoreboarding.
REQ-034 With HAZ_FWD_EN defined, issue loads cnt[id_rd]=1 only when id_is_load=1; non-load writers load 0. Only load-use hazards stall, for one cycle.
REQ-035 With HAZ_FWD_EN undefined, behaviour is exactly as in REQ-018.

Structure
REQ-036 A shared package mips32_pkg holds the FSM state enum, the register-index width constant (5) and the WB_LAT default.
REQ-037 One sub-module, mips32_scoreboard, holds the counters, load/decrement logic and hazard compare; the FSM and stall counter stay in the top level.

Verification
REQ-038 ADDI R10,R0,200 followed immediately by LW R3,0(R10), no FWD -> stall=1 for exactly 2 cycles, bubble with it; stall_cnt=2.
REQ-039 Producer, one independent OR, then consumer, no FWD -> 1 stall cycle; with HAZ_FWD_EN and an ADDI producer -> 0 stall cycles.
REQ-040 LW R3 then a dependent SUBI with HAZ_FWD_EN -> exactly 1 stall cycle; a consumer reading R0 after a write to R0 -> no stall.
REQ-041 BNEQZ issues, ex_br_resolved arrives 2 cycles later with taken=1 -> stall for 2 cycles, flush=1 in the resolve cycle, state back to RUN; with taken=0 -> same stall, flush=0.
REQ-042 HLT issued with cnt[R2]=2 -> DRAIN for 2 cycles, then halted=1 and stall=1 permanently; stall_cnt frozen; rst -> all outputs 0.
REQ-043 CNT_W=4 with a long stall run -> stall_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 hazard controller: FSM encoding, register index width, default latency.
package mips32_pkg;

  localparam int REG_W      = 5;
  localparam int WB_LAT_DEF = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } state_t;

endpackage

// File: rtl/mips32_scoreboard.sv
// Per-register write-back countdown scoreboard for R1..R31 plus the RAW hazard compare.
// HAZ_FWD_EN: only loads arm a counter (to 1); other writers clear their destination's counter.
module mips32_scoreboard
  import mips32_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             valid,
  input  logic             wr_en,
  input  logic [REG_W-1:0] rd,
  input  logic             is_load,
  input  logic [REG_W-1:0] rs,
  input  logic             use_rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rt,
  output logic             hazard,
  output logic             all_zero
);

  logic [1:0]  load_val;
  logic [31:0] busy;

`ifdef HAZ_FWD_EN
  assign load_val = is_load ? 2'd1 : 2'd0;
`else
  logic unused_is_load;
  assign load_val       = 2'(WB_LAT);
  assign unused_is_load = is_load;
`endif

  // R0 is hardwired to zero, so it is never busy.
  assign busy[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [1:0] cnt_reg;

      // A fresh write to this register takes priority over the countdown.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= 2'd0;
        end else if (issue && wr_en && (rd == REG_W'(gi))) begin
          cnt_reg <= load_val;
        end else if (cnt_reg != 2'd0) begin
          cnt_reg <= cnt_reg - 2'd1;
        end
      end

      assign busy[gi] = |cnt_reg;
    end
  endgenerate

  assign hazard   = valid & ((use_rs & busy[rs]) | (use_rt & busy[rt]));
  assign all_zero = ~|busy;

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls from the scoreboard, branch wait, halt drain, stall counter.
// HAZ_FWD_EN: forwarding-aware scoreboarding (only load-use hazards stall, for one cycle).
module mips32_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  input  logic             id_is_hlt,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             hazard, all_zero, issue;

  assign issue = id_valid & ~stall;

  mips32_scoreboard #(
    .WB_LAT (WB_LAT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .valid    (id_valid),
    .wr_en    (id_wr_en),
    .rd       (id_rd),
    .is_load  (id_is_load),
    .rs       (id_rs),
    .use_rs   (id_use_rs),
    .rt       (id_rt),
    .use_rt   (id_use_rt),
    .hazard   (hazard),
    .all_zero (all_zero)
  );

  always_comb begin
    state_next = state_reg;
    flush      = 1'b0;
    case (state_reg)
      RUN: begin
        if (issue && id_is_branch) begin
          state_next = BR_WAIT;
        end else if (issue && id_is_hlt) begin
          state_next = DRAIN;
        end
      end
      BR_WAIT: begin
        // Reset in the resolve cycle abandons the branch without killing IF/ID.
        if (ex_br_resolved) begin
          state_next = RUN;
          flush      = ex_br_taken & ~rst;
        end
      end
      DRAIN: begin
        if (all_zero) begin
          state_next = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Saturate rather than wrap; a halted pipeline no longer counts.
      if (stall && (state_reg != HALT) && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall     = hazard | (state_reg != RUN);
  assign bubble    = stall & id_valid;
  assign halted    = (state_reg == HALT);
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Self-checking bench for mips32_hazard_ctrl (default CNT_W plus a CNT_W=4 copy on shared stimulus).
// Expectations follow HAZ_FWD_EN when the bench is built with that macro.
module tb_mips32_hazard_ctrl;

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        halted;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs, id_use_rt, id_wr_en;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_is_load, id_is_branch, id_is_hlt;
  logic        ex_br_resolved, ex_br_taken;
  logic        stall, bubble, flush, halted;
  logic [15:0] stall_cnt;
  logic        stall4, bubble4, flush4, halted4;
  logic [3:0]  stall_cnt4;

  int   vectors = 0;
  int   miscompares = 0;
  int   m16 = 0;
  int   m4 = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips32_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_hlt(id_is_hlt),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .stall(stall), .bubble(bubble), .flush(flush), .halted(halted), .stall_cnt(stall_cnt)
  );

  mips32_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_hlt(id_is_hlt),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .stall(stall4), .bubble(bubble4), .flush(flush4), .halted(halted4), .stall_cnt(stall_cnt4)
  );

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_rd = 0; id_is_load = 0; id_is_branch = 0; id_is_hlt = 0;
    ex_br_resolved = 0; ex_br_taken = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                           input logic urt, input logic wr, input logic [4:0] rd, input logic ld);
    id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wr_en = wr; id_rd = rd; id_is_load = ld;
  endtask

  // Queue the expected outputs for the inputs now on the bus; advance the stall-count model.
  task automatic push_exp(input logic s, input logic f, input logic h);
    exp_t e;
    e.stall = s; e.bubble = s & id_valid; e.flush = f; e.halted = h;
    e.cnt16 = 16'(m16); e.cnt4 = 4'(m4);
    sb_q.push_back(e);
    if (s && !h) begin
      m16++;
      if (m4 < 15) m4++;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    m16 = 0; m4 = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 1) set_instr(5'd7, 1, 5'd8, 1, 0, 5'd0, 0);
      if (i == 2) begin ex_br_resolved = 1; ex_br_taken = 1; end
      push_exp(0, 0, 0);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  // ADDI R10,R0,200 ; LW R3,0(R10)
  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] es;
    es = FWD ? 6'b000000 : 6'b000110;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0:       set_instr(5'd0, 1, 5'd0, 0, 1, 5'd10, 0);
        1, 2, 3: set_instr(5'd10, 1, 5'd0, 0, 1, 5'd3, 1);
        default: ;
      endcase
      push_exp(es[i], 0, 0);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  // ADDI R5 ; OR R6,R7,R8 ; consumer of R5
  task automatic test_gap();
    exp_t e;
    logic [5:0] es;
    es = FWD ? 6'b000000 : 6'b000100;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0:       set_instr(5'd0, 1, 5'd0, 0, 1, 5'd5, 0);
        1:       set_instr(5'd7, 1, 5'd8, 1, 1, 5'd6, 0);
        2, 3:    set_instr(5'd5, 1, 5'd0, 0, 1, 5'd9, 0);
        default: ;
      endcase
      push_exp(es[i], 0, 0);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL gap[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  // LW R3 ; SUBI R4,R3 ; write R0 ; read R0
  task automatic test_load_use();
    exp_t e;
    logic [7:0] es;
    es = FWD ? 8'b00000010 : 8'b00000110;
    for (int i = 0; i < 8; i++) begin
      idle();
      case (i)
        0:       set_instr(5'd0, 1, 5'd0, 0, 1, 5'd3, 1);
        1, 2, 3: set_instr(5'd3, 1, 5'd0, 0, 1, 5'd4, 0);
        4:       set_instr(5'd0, 0, 5'd0, 0, 1, 5'd0, 0);
        5:       set_instr(5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
        default: ;
      endcase
      push_exp(es[i], 0, 0);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  // BNEQZ, resolve two cycles later (taken, then not taken), then a stray resolve in RUN.
  task automatic test_branch();
    exp_t e;
    logic [4:0] es, ef;
    for (int p = 0; p < 2; p++) begin
      es = 5'b00110;
      ef = (p == 0) ? 5'b00100 : 5'b00000;
      for (int i = 0; i < 5; i++) begin
        idle();
        case (i)
          0: begin set_instr(5'd1, 1, 5'd0, 0, 0, 5'd0, 0); id_is_branch = 1; end
          1, 3: set_instr(5'd2, 1, 5'd0, 0, 0, 5'd0, 0);
          2: begin
            set_instr(5'd2, 1, 5'd0, 0, 0, 5'd0, 0);
            ex_br_resolved = 1; ex_br_taken = (p == 0);
          end
          default: begin ex_br_resolved = 1; ex_br_taken = 1; end
        endcase
        push_exp(es[i], ef[i], 0);
        @(negedge clk);
        e = sb_q.pop_front();
        vectors++;
        if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
            {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
          miscompares++;
          $display("FAIL branch_p%0d[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                   p, i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                   e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Long branch wait pushes the 4-bit counter past 15.
  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 23; i++) begin
      idle();
      if (i == 0) begin set_instr(5'd1, 1, 5'd0, 0, 0, 5'd0, 0); id_is_branch = 1; end
      if (i == 21) ex_br_resolved = 1;
      push_exp((i >= 1 && i <= 21), 0, 0);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  // ADDI R2 ; HLT -> drain, halt, then reset clears everything.
  task automatic test_halt();
    exp_t e;
    logic [7:0] es, eh;
    es = 8'b01111100;
    eh = FWD ? 8'b01111000 : 8'b01110000;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) do_reset();
      idle();
      case (i)
        0: set_instr(5'd0, 1, 5'd0, 0, 1, 5'd2, 0);
        1: begin set_instr(5'd0, 0, 5'd0, 0, 0, 5'd0, 0); id_is_hlt = 1; end
        5: begin
          set_instr(5'd3, 1, 5'd0, 0, 1, 5'd4, 0);
          ex_br_resolved = 1; ex_br_taken = 1;
        end
        default: ;
      endcase
      push_exp(es[i], 0, eh[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL halt[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset while waiting on a branch, with a taken resolve on the bus around it.
  task automatic test_reset_abort();
    exp_t e;
    logic [2:0] es;
    es = 3'b010;
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 2) begin
        ex_br_resolved = 1; ex_br_taken = 1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m16 = 0; m4 = 0;
      end
      if (i == 0) begin set_instr(5'd1, 1, 5'd0, 0, 0, 5'd0, 0); id_is_branch = 1; end
      push_exp(es[i], 0, 0);
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({stall, bubble, flush, halted, stall_cnt, stall_cnt4} !== e ||
          {stall4, bubble4, flush4, halted4} !== {e.stall, e.bubble, e.flush, e.halted}) begin
        miscompares++;
        $display("FAIL reset_abort[%0d]: got s/b/f/h=%b%b%b%b cnt=%0d cnt4=%0d s4/b4/f4/h4=%b%b%b%b, want %b%b%b%b cnt=%0d cnt4=%0d",
                 i, stall, bubble, flush, halted, stall_cnt, stall_cnt4, stall4, bubble4, flush4, halted4,
                 e.stall, e.bubble, e.flush, e.halted, e.cnt16, e.cnt4);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_back_to_back();
    test_gap();
    test_load_use();
    test_branch();
    test_saturation();
    test_halt();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
